mdu_issue_ctrl: RTL and testbench

CPU-side counterpart of the MDU controller. It sits in the EX stage between the pipeline and the multiply/divide unit. It accepts one M-extension instruction at a time from EX, stalls the pipeline, and issues operands to the MDU with a valid/busy handshake. It holds `cpu_busy` until the MDU result is captured, then presents the result to writeback with a valid/ready handshake.

---
 rtl/mdu_issue_ctrl.sv | 115 +++++++++++
 tb/tb_mdu_issue_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_issue_ctrl.sv
// EX-stage issue controller for the multiply/divide unit: stalls the pipeline, issues one
// M-op to the MDU with valid/busy, captures the result and hands it to writeback.
module mdu_issue_ctrl #(
  parameter int unsigned XLEN   = 32,
  parameter bit          DIV_EN = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic [4:0]      ex_rd,
  input  logic            flush,
  output logic            ex_stall,
  output logic            ill_op,
  output logic            mdu_in_valid,
  output logic [2:0]      mdu_funct3,
  output logic [XLEN-1:0] mdu_rs1,
  output logic [XLEN-1:0] mdu_rs2,
  input  logic            mdu_busy,
  input  logic            mdu_out_valid,
  input  logic [XLEN-1:0] mdu_result,
  output logic            cpu_busy,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  input  logic            wb_ready,
  output logic [31:0]     mdu_cycles
);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StResp,
    StDrain
  } state_e;

  state_e state_q;

  logic in_idle, in_issue, in_wait, in_resp, in_drain;
  logic req, accept;

  assign in_idle  = (state_q == StIdle);
  assign in_issue = (state_q == StIssue);
  assign in_wait  = (state_q == StWait);
  assign in_resp  = (state_q == StResp);
  assign in_drain = (state_q == StDrain);

  // flush always wins over a new request
  assign req    = in_idle & ex_valid & ~flush;
  assign accept = req & (~ex_funct3[2] | DIV_EN);
  assign ill_op = req & ex_funct3[2] & ~DIV_EN;

  assign mdu_in_valid = in_issue;
  assign cpu_busy     = in_issue | in_wait | in_drain;
  assign wb_valid     = in_resp;
  assign ex_stall     = accept | in_issue | in_wait | in_drain | (in_resp & ~wb_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      mdu_funct3 <= '0;
      mdu_rs1    <= '0;
      mdu_rs2    <= '0;
      wb_rd      <= '0;
      wb_data    <= '0;
      mdu_cycles <= '0;
    end else begin
      if (!in_idle) begin
        mdu_cycles <= mdu_cycles + 32'd1;
      end
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            mdu_funct3 <= ex_funct3;
            mdu_rs1    <= ex_rs1;
            mdu_rs2    <= ex_rs2;
            wb_rd      <= ex_rd;
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          // Once the MDU has taken the op it cannot be aborted, so a flush must drain it.
          if (!mdu_busy) begin
            state_q <= flush ? StDrain : StWait;
          end else if (flush) begin
            state_q <= StIdle;
          end
        end
        StWait: begin
          if (flush) begin
            state_q <= mdu_out_valid ? StIdle : StDrain;
          end else if (mdu_out_valid) begin
            wb_data <= mdu_result;
            state_q <= StResp;
          end
        end
        StResp: begin
          if (flush || wb_ready) begin
            state_q <= StIdle;
          end
        end
        StDrain: begin
          if (mdu_out_valid) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Bench for mdu_issue_ctrl: a 64-cycle multiplier model, directed ops, and a writeback
// scoreboard fed by the stimulus and drained by an independent monitor.
module tb_mdu_issue_ctrl;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            ex_valid;
  logic [2:0]      ex_funct3;
  logic [XLEN-1:0] ex_rs1, ex_rs2;
  logic [4:0]      ex_rd;
  logic            flush;
  logic            ex_stall, ill_op, mdu_in_valid;
  logic [2:0]      mdu_funct3;
  logic [XLEN-1:0] mdu_rs1, mdu_rs2;
  logic            mdu_busy, mdu_out_valid;
  logic [XLEN-1:0] mdu_result;
  logic            cpu_busy, wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            wb_ready;
  logic [31:0]     mdu_cycles;

  int checks = 0;
  int errors = 0;
  logic [36:0] sb_q[$];

  always #5 clk = ~clk;

  mdu_issue_ctrl #(.XLEN(XLEN), .DIV_EN(1'b0)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .ex_funct3    (ex_funct3),
    .ex_rs1       (ex_rs1),
    .ex_rs2       (ex_rs2),
    .ex_rd        (ex_rd),
    .flush        (flush),
    .ex_stall     (ex_stall),
    .ill_op       (ill_op),
    .mdu_in_valid (mdu_in_valid),
    .mdu_funct3   (mdu_funct3),
    .mdu_rs1      (mdu_rs1),
    .mdu_rs2      (mdu_rs2),
    .mdu_busy     (mdu_busy),
    .mdu_out_valid(mdu_out_valid),
    .mdu_result   (mdu_result),
    .cpu_busy     (cpu_busy),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .wb_ready     (wb_ready),
    .mdu_cycles   (mdu_cycles)
  );

  // Multiplier model: 64 busy cycles after the handshake, result held until cpu_busy drops.
  logic        mrun, mdone, force_busy;
  logic [6:0]  mcnt;
  logic [31:0] mres;

  always @(posedge clk) begin
    if (rst) begin
      mrun  <= 1'b0;
      mdone <= 1'b0;
      mcnt  <= '0;
      mres  <= '0;
    end else if (!mrun && !mdone && mdu_in_valid && !mdu_busy) begin
      mrun <= 1'b1;
      mcnt <= '0;
      mres <= 32'(mdu_rs1 * mdu_rs2);
    end else if (mrun) begin
      if (mcnt == 7'd63) begin
        mrun  <= 1'b0;
        mdone <= 1'b1;
      end else begin
        mcnt <= mcnt + 7'd1;
      end
    end else if (mdone && !cpu_busy) begin
      mdone <= 1'b0;
    end
  end

  assign mdu_busy      = mrun | mdone | force_busy;
  assign mdu_out_valid = mdone;
  assign mdu_result    = mres;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every writeback must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && wb_valid && wb_ready && !flush) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got rd %0d data %0h expected none", wb_rd, wb_data);
      end else begin
        logic [36:0] e;
        e = sb_q.pop_front();
        chk("wb_rd", 32'(wb_rd), 32'(e[36:32]));
        chk("wb_data", wb_data, e[31:0]);
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    ex_valid  = 1'b1;
    ex_funct3 = f;
    ex_rs1    = a;
    ex_rs2    = b;
    ex_rd     = rd;
  endtask

  // Returns at the falling edge of the first wb_valid cycle, or after the bound expires.
  task automatic wait_wb(input int bound);
    int cyc;
    cyc = 0;
    @(negedge clk);
    while (!wb_valid && cyc < bound) begin
      next();
      @(negedge clk);
      cyc++;
    end
    chk("wb_seen", 32'(wb_valid), 32'd1);
  endtask

  int iv_cnt, iv_first, st_cnt, st_late, wb_first, hold, bad, busy_seen, mdu_act, early;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_funct3 = '0; ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0;
    flush = 1'b0; wb_ready = 1'b0; force_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_valid", 32'(mdu_in_valid), 32'd0);
    chk("rst_cpu_busy", 32'(cpu_busy), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_stall", 32'(ex_stall), 32'd0);
    chk("rst_rs1", mdu_rs1, 32'd0);
    chk("rst_cycles", mdu_cycles, 32'd0);
    next();

    // MUL 7*6 -> 42, full cycle timeline
    wb_ready = 1'b1;
    sb_q.push_back({5'd5, 32'd42});
    iv_cnt = 0; iv_first = -1; st_cnt = 0; st_late = 0; wb_first = -1;
    for (int c = 0; c <= 67; c++) begin
      if (c == 0) issue(3'd0, 32'd7, 32'd6, 5'd5);
      else ex_valid = 1'b0;
      @(negedge clk);
      if (mdu_in_valid) begin
        iv_cnt++;
        if (iv_first < 0) iv_first = c;
      end
      if (ex_stall) begin
        if (c <= 66) st_cnt++;
        else st_late++;
      end
      if (wb_valid && wb_first < 0) wb_first = c;
      next();
    end
    chk("mul_iv_count", 32'(iv_cnt), 32'd1);
    chk("mul_iv_cycle", 32'(iv_first), 32'd1);
    chk("mul_stall_0_66", 32'(st_cnt), 32'd67);
    chk("mul_stall_67", 32'(st_late), 32'd0);
    chk("mul_wb_cycle", 32'(wb_first), 32'd67);
    @(negedge clk);
    chk("mul_cycles", mdu_cycles, 32'd67);
    chk("mul_wb_drop", 32'(wb_valid), 32'd0);
    next();

    // MUL 3*4 with 10 cycles of writeback backpressure
    wb_ready = 1'b0;
    sb_q.push_back({5'd9, 32'd12});
    issue(3'd0, 32'd3, 32'd4, 5'd9);
    next();
    ex_valid = 1'b0;
    wait_wb(100);
    hold = 0; bad = 0; busy_seen = 0; mdu_act = 0;
    for (int k = 0; k <= 10; k++) begin
      if (wb_valid) hold++;
      if (wb_data !== 32'd12) bad++;
      if (cpu_busy) busy_seen++;
      if (k >= 1 && mdu_busy) mdu_act++;
      next();
      wb_ready = (k == 9);
      @(negedge clk);
    end
    chk("bp_hold", 32'(hold), 32'd11);
    chk("bp_data_stable", 32'(bad), 32'd0);
    chk("bp_cpu_busy", 32'(busy_seen), 32'd0);
    chk("bp_mdu_idle", 32'(mdu_act), 32'd0);
    chk("bp_wb_drop", 32'(wb_valid), 32'd0);
    next();
    wb_ready = 1'b1;

    // Issue held off by a busy MDU for 5 cycles
    sb_q.push_back({5'd3, 32'd25});
    issue(3'd0, 32'd5, 32'd5, 5'd3);
    force_busy = 1'b1;
    iv_cnt = 0; early = 0;
    for (int c = 0; c <= 9; c++) begin
      if (c == 1) ex_valid = 1'b0;
      if (c == 6) force_busy = 1'b0;
      @(negedge clk);
      if (mdu_in_valid) iv_cnt++;
      if (c <= 6 && mrun) early++;
      if (c == 7) chk("busy_mdu_started", 32'(mrun), 32'd1);
      next();
    end
    chk("busy_iv_count", 32'(iv_cnt), 32'd6);
    chk("busy_no_early", 32'(early), 32'd0);
    wait_wb(100);
    next();

    // Flush in WAIT, drain, then MUL 2*2
    issue(3'd0, 32'd9, 32'd9, 5'd7);
    bad = 0; hold = 0;
    for (int c = 0; c <= 67; c++) begin
      if (c == 1) ex_valid = 1'b0;
      flush = (c == 21);
      @(negedge clk);
      if (c >= 22 && c <= 66 && !cpu_busy) bad++;
      if (wb_valid) hold++;
      if (c == 66) chk("drain_out_valid", 32'(mdu_out_valid), 32'd1);
      if (c == 67) begin
        chk("drain_idle_busy", 32'(cpu_busy), 32'd0);
        chk("drain_idle_stall", 32'(ex_stall), 32'd0);
      end
      next();
    end
    flush = 1'b0;
    chk("drain_cpu_busy", 32'(bad), 32'd0);
    chk("drain_no_wb", 32'(hold), 32'd0);
    sb_q.push_back({5'd1, 32'd4});
    issue(3'd0, 32'd2, 32'd2, 5'd1);
    next();
    ex_valid = 1'b0;
    wait_wb(100);
    next();

    // Illegal divide with DIV_EN=0
    issue(3'd4, 32'd8, 32'd2, 5'd4);
    @(negedge clk);
    chk("ill_op", 32'(ill_op), 32'd1);
    chk("ill_stall", 32'(ex_stall), 32'd0);
    next();
    ex_valid = 1'b0;
    iv_cnt = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (mdu_in_valid || cpu_busy) iv_cnt++;
      if (c == 1) chk("ill_op_drop", 32'(ill_op), 32'd0);
      next();
    end
    chk("ill_no_issue", 32'(iv_cnt), 32'd0);

    // Reset while in RESP
    wb_ready = 1'b0;
    issue(3'd0, 32'd10, 32'd10, 5'd2);
    next();
    ex_valid = 1'b0;
    wait_wb(100);
    chk("rresp_data", wb_data, 32'd100);
    next();
    rst = 1'b1;
    next();
    rst = 1'b0;
    @(negedge clk);
    chk("rresp_wb_valid", 32'(wb_valid), 32'd0);
    chk("rresp_wb_data", wb_data, 32'd0);
    chk("rresp_wb_rd", 32'(wb_rd), 32'd0);
    chk("rresp_rs1", mdu_rs1, 32'd0);
    chk("rresp_cycles", mdu_cycles, 32'd0);
    chk("rresp_stall", 32'(ex_stall), 32'd0);
    next();

    // Flush coincident with ex_valid in IDLE
    wb_ready = 1'b1;
    issue(3'd0, 32'd1, 32'd1, 5'd1);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_ev_stall", 32'(ex_stall), 32'd0);
    next();
    ex_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_ev_no_issue", 32'(mdu_in_valid), 32'd0);
    chk("flush_ev_idle", 32'(cpu_busy), 32'd0);
    next();

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
